// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg
//   Shared definitions for the ADC0808/0809 scan scheduler: FSM state
//   encoding, default timing constants and a small sizing helper.
//   No ports; imported with "import adc_scan_pkg::*".
package adc_scan_pkg;

  // Explicit encodings keep state values stable across tool runs.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_READ    = 3'd5,
    ST_PACE    = 3'd6
  } scan_state_t;

  localparam int DEF_NCH      = 8;
  localparam int DEF_DW       = 8;
  localparam int DEF_START_W  = 2;
  localparam int DEF_OE_W     = 2;
  localparam int DEF_PACE_CYC = 100;
  localparam int DEF_TO_CYC   = 1024;

  // Sizes the shared START/OE/PACE counter from its largest terminal count.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adc_scan_if.sv
// adc_scan_if
//   Pin bundle between the scan scheduler and an ADC0808/0809-class part.
//   Parameters: NCH (channel count, addr width = $clog2(NCH)), DW (data width).
//   Signals:
//     ale      address latch enable (scheduler -> ADC)
//     start    conversion start     (scheduler -> ADC)
//     oe       output enable        (scheduler -> ADC)
//     addr     channel address      (scheduler -> ADC)
//     eoc      end of conversion, already synchronised (ADC -> scheduler)
//     adc_data conversion result bus, valid while oe=1  (ADC -> scheduler)
//   Modports: master = scheduler side, slave = converter side.
import adc_scan_pkg::*;

interface adc_scan_if #(
  parameter int NCH = DEF_NCH,
  parameter int DW  = DEF_DW
);
  logic                   ale;
  logic                   start;
  logic                   oe;
  logic [$clog2(NCH)-1:0] addr;
  logic                   eoc;
  logic [DW-1:0]          adc_data;

  modport master (output ale, start, oe, addr, input eoc, adc_data);
  modport slave  (input ale, start, oe, addr, output eoc, adc_data);
endinterface

// File: rtl/adc_next_chan.sv
// adc_next_chan
//   Combinational round-robin finder. Returns the first set bit of mask
//   strictly after cur, wrapping NCH-1 -> 0. cur itself is examined last,
//   so a lone enabled channel reselects itself.
//   Ports:
//     mask  in  NCH      channel enable mask
//     cur   in  log2NCH  channel most recently converted
//     next  out log2NCH  next channel to convert (cur when none found)
//     found out 1        at least one mask bit is set
import adc_scan_pkg::*;

module adc_next_chan #(
  parameter int NCH = DEF_NCH
) (
  input  logic [NCH-1:0]         mask,
  input  logic [$clog2(NCH)-1:0] cur,
  output logic [$clog2(NCH)-1:0] next,
  output logic                   found
);
  localparam int AW = $clog2(NCH);

  logic [AW-1:0] cand;

  // Scan from the farthest candidate to the nearest; the nearest hit is
  // written last and therefore wins.
  always_comb begin
    next  = cur;
    found = 1'b0;
    cand  = '0;
    for (int i = NCH; i >= 1; i--) begin
      cand = AW'((int'(cur) + i) % NCH);
      if (mask[cand]) begin
        next  = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler
//   Round-robin scan sequencer for an ADC0808/0809-class converter. For each
//   channel enabled in chan_mask it runs address/ALE, START, EOC wait and OE
//   read, then presents the result as a one-cycle sample_valid strobe.
//   Optional feature macro: ADC_SCAN_TIMEOUT_EN (EOC watchdog of TO_CYC cycles).
//   Ports:
//     clk, reset_n  clock, asynchronous active-low reset
//     enable        level-sensitive scan enable
//     chan_mask     1 = channel included in scan
//     adc           adc_scan_if.master pin bundle (ale/start/oe/addr/eoc/adc_data)
//     sample_valid  1-cycle strobe, sample_chan/sample_data valid
//     sample_chan   channel of last sample or timed-out conversion
//     sample_data   last captured result, held until next capture
//     busy          high in every state except IDLE
//     timeout_err   1-cycle strobe on watchdog expiry (0 without the macro)
module adc_scan_scheduler
  import adc_scan_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int DW       = DEF_DW,
  parameter int START_W  = DEF_START_W,
  parameter int OE_W     = DEF_OE_W,
  parameter int PACE_CYC = DEF_PACE_CYC,
  parameter int TO_CYC   = DEF_TO_CYC
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [NCH-1:0]         chan_mask,
  adc_scan_if.master             adc,
  output logic                   sample_valid,
  output logic [$clog2(NCH)-1:0] sample_chan,
  output logic [DW-1:0]          sample_data,
  output logic                   busy,
  output logic                   timeout_err
);
  localparam int AW = $clog2(NCH);
  localparam int CW = $clog2(max3(START_W, OE_W, PACE_CYC) + 1);

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt;
  logic [AW-1:0] cur_chan, addr_q, next_chan;
  logic          found;
  logic          cnt_clr, cnt_inc, sel, capture, to_fire;
  logic          wd_expired, pace_done;

  adc_next_chan #(.NCH(NCH)) u_next (
    .mask  (chan_mask),
    .cur   (cur_chan),
    .next  (next_chan),
    .found (found)
  );

  // PACE_CYC = 0 still spends one cycle in PACE.
  assign pace_done = (int'(cnt) + 1 >= PACE_CYC);

  assign adc.ale   = (state_q == ST_SETUP);
  assign adc.start = (state_q == ST_START);
  assign adc.oe    = (state_q == ST_READ);
  assign adc.addr  = addr_q;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode plus the control strobes for the datapath below.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    sel     = 1'b0;
    capture = 1'b0;
    to_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && found) begin
          sel     = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_clr = 1'b1;
        state_d = ST_START;
      end
      ST_START: begin
        if (cnt == CW'(START_W - 1)) begin
          cnt_clr = 1'b1;
          state_d = ST_WAIT_LO;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!adc.eoc) begin
          state_d = ST_WAIT_HI;
        end else if (wd_expired) begin
          to_fire = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_PACE;
        end
      end
      ST_WAIT_HI: begin
        if (adc.eoc) begin
          cnt_clr = 1'b1;
          state_d = ST_READ;
        end else if (wd_expired) begin
          to_fire = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_PACE;
        end
      end
      ST_READ: begin
        if (cnt == CW'(OE_W - 1)) begin
          capture = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_PACE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_PACE: begin
        if (pace_done) begin
          if (enable && found) begin
            sel     = 1'b1;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // cur_chan resets to NCH-1 so the first selection lands on channel 0;
  // addr_q is kept separately so addr reads 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      cur_chan     <= AW'(NCH - 1);
      addr_q       <= '0;
      sample_valid <= 1'b0;
      sample_chan  <= '0;
      sample_data  <= '0;
    end else begin
      sample_valid <= capture;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (sel) begin
        cur_chan <= next_chan;
        addr_q   <= next_chan;
      end
      if (capture) begin
        sample_data <= adc.adc_data;
        sample_chan <= cur_chan;
      end else if (to_fire) begin
        sample_chan <= cur_chan;
      end
    end
  end

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int WW = $clog2(TO_CYC + 1);
  logic [WW-1:0] wd;

  // Counts every cycle spent waiting on EOC; zero on entry to WAIT_LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_fire;
      if (state_q == ST_WAIT_LO || state_q == ST_WAIT_HI) wd <= wd + 1'b1;
      else                                                wd <= '0;
    end
  end

  assign wd_expired = (wd == WW'(TO_CYC - 1));
`else
  localparam int unused_to_cyc = TO_CYC;
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb_adc_scan_scheduler
//   Directed bench for adc_scan_scheduler with a behavioural ADC0808 model.
//   Expected addresses and samples are queued by the stimulus and consumed
//   by an independent monitor whenever the DUT strobes ale or sample_valid.
module tb_adc_scan_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] chan_mask = 8'h00;
  logic       sample_valid, busy, timeout_err;
  logic [2:0] sample_chan;
  logic [7:0] sample_data;
  logic       stuck = 1'b0;

  int check_count = 0;
  int pass_count  = 0;
  int cyc = 0;
  int ale_cnt = 0, start_cnt = 0, oe_cnt = 0, valid_cnt = 0, to_cnt = 0;
  int excl_viol = 0;
  int ale_cyc[$];
  int valid_cyc[$];
  int to_cyc_q[$];
  logic [2:0]  exp_addr_q[$];
  logic [10:0] exp_samp_q[$];
  int b_ale, b_start, b_oe, b_val, b_to;

  adc_scan_if #(.NCH(8), .DW(8)) adc_bus ();

  adc_scan_scheduler #(
    .NCH(8), .DW(8), .START_W(2), .OE_W(2), .PACE_CYC(10), .TO_CYC(64)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .chan_mask    (chan_mask),
    .adc          (adc_bus),
    .sample_valid (sample_valid),
    .sample_chan  (sample_chan),
    .sample_data  (sample_data),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] mask);
    enable    = en;
    chan_mask = mask;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset_n = 1'b0;
    applyStimulus(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic waitValid(input int target, input int budget, input string name);
    for (int i = 0; i < budget && valid_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    if (valid_cnt < target) checkOutput(name, valid_cnt, target);
  endtask

  task automatic waitAle(input int target, input int budget, input string name);
    for (int i = 0; i < budget && ale_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    if (ale_cnt < target) checkOutput(name, ale_cnt, target);
  endtask

  task automatic waitIdle(input int budget, input string name);
    for (int i = 0; i < budget && busy; i++) begin
      @(negedge clk);
      #1;
    end
    if (busy) checkOutput(name, busy, 0);
  endtask

  function automatic logic [7:0] chanData(input logic [2:0] ch);
    return 8'(8'hA5 + 8'h11 * ch);
  endfunction

  // ADC model: EOC falls 3 cycles after START is seen, rises 20 cycles later.
  initial begin
    int conv_t;
    logic prev_start;
    conv_t = 0;
    prev_start = 1'b0;
    adc_bus.eoc = 1'b1;
    adc_bus.adc_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        conv_t = 0;
        adc_bus.eoc = 1'b1;
      end else begin
        if (adc_bus.ale) adc_bus.adc_data = chanData(adc_bus.addr);
        if (adc_bus.start && !prev_start && !stuck) conv_t = 1;
        else if (conv_t > 0) conv_t++;
        if (conv_t == 4) adc_bus.eoc = 1'b0;
        if (conv_t == 24) begin
          adc_bus.eoc = 1'b1;
          conv_t = 0;
        end
      end
      prev_start = adc_bus.start;
    end
  end

  // Monitor: scoreboards addresses at ale and samples at sample_valid.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (adc_bus.ale) begin
        ale_cnt++;
        ale_cyc.push_back(cyc);
        if (exp_addr_q.size() == 0) checkOutput("ale_unexpected", 1, 0);
        else checkOutput("addr", {29'd0, adc_bus.addr}, {29'd0, exp_addr_q.pop_front()});
      end
      if (adc_bus.start) start_cnt++;
      if (adc_bus.oe) oe_cnt++;
      if (adc_bus.start && adc_bus.oe) excl_viol++;
      if (timeout_err) begin
        to_cnt++;
        to_cyc_q.push_back(cyc);
      end
      if (sample_valid) begin
        valid_cnt++;
        valid_cyc.push_back(cyc);
        if (exp_samp_q.size() == 0) begin
          checkOutput("sample_unexpected", 1, 0);
        end else begin
          e = exp_samp_q.pop_front();
          checkOutput("sample_chan", {29'd0, sample_chan}, {29'd0, e[10:8]});
          checkOutput("sample_data", {24'd0, sample_data}, {24'd0, e[7:0]});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: actual=%0d required=finish", cyc);
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    // Test 1: single channel, reset values and pulse widths
    applyReset();
    checkOutput("rst_ale", adc_bus.ale, 0);
    checkOutput("rst_start", adc_bus.start, 0);
    checkOutput("rst_oe", adc_bus.oe, 0);
    checkOutput("rst_addr", {29'd0, adc_bus.addr}, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", sample_valid, 0);
    checkOutput("rst_chan", {29'd0, sample_chan}, 0);
    checkOutput("rst_data", {24'd0, sample_data}, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    b_ale = ale_cnt; b_start = start_cnt; b_oe = oe_cnt; b_val = valid_cnt;
    exp_addr_q.push_back(3'd0);
    exp_samp_q.push_back({3'd0, 8'hA5});
    applyStimulus(1'b1, 8'h01);
    waitValid(b_val + 1, 200, "t1_wait_valid");
    applyStimulus(1'b0, 8'h01);
    waitIdle(100, "t1_wait_idle");
    checkOutput("t1_ale_cycles", ale_cnt - b_ale, 1);
    checkOutput("t1_start_cycles", start_cnt - b_start, 2);
    checkOutput("t1_oe_cycles", oe_cnt - b_oe, 2);
    checkOutput("t1_latency", valid_cyc[b_val] - ale_cyc[b_ale], 27);
    checkOutput("t1_data_hold", {24'd0, sample_data}, 32'hA5);

    // Test 2: mask 25 visits 0,2,5,0,2 with fixed SETUP spacing
    applyReset();
    b_ale = ale_cnt; b_val = valid_cnt;
    exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd2); exp_addr_q.push_back(3'd5);
    exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd2);
    exp_samp_q.push_back({3'd0, 8'hA5}); exp_samp_q.push_back({3'd2, 8'hC7});
    exp_samp_q.push_back({3'd5, 8'hFA}); exp_samp_q.push_back({3'd0, 8'hA5});
    exp_samp_q.push_back({3'd2, 8'hC7});
    applyStimulus(1'b1, 8'h25);
    waitValid(b_val + 5, 600, "t2_wait_valid");
    applyStimulus(1'b0, 8'h25);
    waitIdle(100, "t2_wait_idle");
    checkOutput("t2_ale_count", ale_cnt - b_ale, 5);
    checkOutput("t2_spacing_a", ale_cyc[b_ale + 1] - ale_cyc[b_ale], 37);
    checkOutput("t2_spacing_b", ale_cyc[b_ale + 2] - ale_cyc[b_ale + 1], 37);

    // Test 3: mask switches to 18 while channel 2 converts
    applyReset();
    b_ale = ale_cnt; b_val = valid_cnt;
    exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd2); exp_addr_q.push_back(3'd3);
    exp_addr_q.push_back(3'd4); exp_addr_q.push_back(3'd3);
    exp_samp_q.push_back({3'd0, 8'hA5}); exp_samp_q.push_back({3'd2, 8'hC7});
    exp_samp_q.push_back({3'd3, 8'hD8}); exp_samp_q.push_back({3'd4, 8'hE9});
    exp_samp_q.push_back({3'd3, 8'hD8});
    applyStimulus(1'b1, 8'h25);
    waitAle(b_ale + 2, 200, "t3_wait_ch2");
    repeat (5) @(negedge clk);
    #1;
    applyStimulus(1'b1, 8'h18);
    waitValid(b_val + 5, 600, "t3_wait_valid");
    applyStimulus(1'b0, 8'h18);
    waitIdle(100, "t3_wait_idle");
    checkOutput("t3_ale_count", ale_cnt - b_ale, 5);

    // Test 4: enable dropped during WAIT_HI
    applyReset();
    b_ale = ale_cnt; b_val = valid_cnt;
    exp_addr_q.push_back(3'd0);
    exp_samp_q.push_back({3'd0, 8'hA5});
    applyStimulus(1'b1, 8'h01);
    for (int i = 0; i < 100 && adc_bus.eoc; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("t4_eoc_low", adc_bus.eoc, 0);
    repeat (5) @(negedge clk);
    #1;
    applyStimulus(1'b0, 8'h01);
    waitValid(b_val + 1, 200, "t4_wait_valid");
    waitIdle(100, "t4_wait_idle");
    repeat (60) @(negedge clk);
    #1;
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_ale_count", ale_cnt - b_ale, 1);
    checkOutput("t4_valid_count", valid_cnt - b_val, 1);

    // Test 5: asynchronous reset during READ, scan restarts at channel 0
    applyReset();
    b_ale = ale_cnt; b_val = valid_cnt;
    exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd0);
    exp_samp_q.push_back({3'd0, 8'hA5});
    applyStimulus(1'b1, 8'h03);
    for (int i = 0; i < 200 && !adc_bus.oe; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("t5_oe_seen", adc_bus.oe, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t5_async_oe", adc_bus.oe, 0);
    checkOutput("t5_async_start", adc_bus.start, 0);
    checkOutput("t5_async_ale", adc_bus.ale, 0);
    checkOutput("t5_async_busy", busy, 0);
    checkOutput("t5_async_valid", sample_valid, 0);
    checkOutput("t5_async_data", {24'd0, sample_data}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    waitValid(b_val + 1, 200, "t5_wait_valid");
    applyStimulus(1'b0, 8'h03);
    waitIdle(100, "t5_wait_idle");
    checkOutput("t5_ale_count", ale_cnt - b_ale, 2);
    checkOutput("t5_valid_count", valid_cnt - b_val, 1);

`ifdef ADC_SCAN_TIMEOUT_EN
    // Test 6: EOC stuck high, watchdog advances the scan
    applyReset();
    stuck = 1'b1;
    b_ale = ale_cnt; b_val = valid_cnt; b_to = to_cnt;
    exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd1);
    applyStimulus(1'b1, 8'h03);
    for (int i = 0; i < 300 && to_cnt < b_to + 1; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("t6_timeout_seen", to_cnt - b_to, 1);
    checkOutput("t6_timeout_chan", {29'd0, sample_chan}, 0);
    checkOutput("t6_timeout_latency", to_cyc_q[b_to] - ale_cyc[b_ale], 67);
    checkOutput("t6_data_kept", {24'd0, sample_data}, 0);
    waitAle(b_ale + 2, 100, "t6_wait_next");
    applyStimulus(1'b0, 8'h03);
    waitIdle(300, "t6_wait_idle");
    checkOutput("t6_timeout_count", to_cnt - b_to, 2);
    checkOutput("t6_no_valid", valid_cnt - b_val, 0);
    stuck = 1'b0;
`else
    checkOutput("no_timeout_strobe", to_cnt, 0);
`endif

    checkOutput("start_oe_exclusive", excl_viol, 0);
    checkOutput("addr_queue_drained", exp_addr_q.size(), 0);
    checkOutput("sample_queue_drained", exp_samp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
